// File: rtl/hilo_div_seq.sv
// Multi-cycle restoring divider producing {HI, LO} = {remainder, quotient}
// for DIV/DIVU, one quotient bit per cycle, with annul for pipeline flushes.
module hilo_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] w_q, w_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] a_abs, b_abs, quot, rem;
  logic [32:0] diff;

  // The working register's top bit is provably always zero, so only 64 bits are kept.
  always_comb begin
    a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    diff  = w_q[63:31] - {1'b0, b_q};
    quot  = (sgn_q && (a_neg_q ^ b_neg_q)) ? (~w_q[31:0] + 32'd1) : w_q[31:0];
    rem   = (sgn_q && a_neg_q) ? (~w_q[63:32] + 32'd1) : w_q[63:32];

    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          sgn_d   = signed_div_i;
          a_neg_d = opdata1_i[31];
          b_neg_d = opdata2_i[31];
          b_d     = b_abs;
          cnt_d   = 6'd0;
          if (opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
            w_d     = 64'd0;
          end else begin
            state_d = S_ON;
            w_d     = {32'd0, a_abs};
          end
        end
      end
      S_BYZERO: begin
        result_d = 64'd0;
        if (annul_i) begin
          state_d = S_FREE;
          ready_d = 1'b0;
        end else begin
          state_d = S_END;
          ready_d = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          if (diff[32]) w_d = {w_q[62:0], 1'b0};
          else          w_d = {diff[31:0], w_q[30:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = S_END;
          cnt_d    = 6'd0;
          result_d = {rem, quot};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      w_q      <= 64'd0;
      b_q      <= 32'd0;
      sgn_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~annul_i & ~ready_q;

endmodule
